// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one single-port text-mode video RAM between the display
// fetch engine (absolute priority, fixed 2-clock read latency) and a host write
// port that is buffered in a small FIFO and drained only in slots where the
// display does not request the RAM.
//
// Ports:
//   clk, nrst           dot clock, synchronous active-low reset
//   dispReq/dispAddr    display fetch request and address, sampled every edge
//   dispValid/dispData  registered read return, valid 2 edges after the request
//   hostWr/hostAddr/hostData  host write strobe, one FIFO entry per cycle high
//   hostFull/hostCount  FIFO full flag and occupancy (0..FIFO_DEPTH)
//   hostOverflow        sticky flag: a host write was dropped on a full FIFO
//   ramAddr/ramWrData/ramWe/ramRe  registered RAM command outputs
//   ramRdData           synchronous RAM read data, valid the cycle after ramRe
module vram_arbiter #(
    parameter int unsigned ADDR_W     = 12,
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          nrst,
    input  logic                          dispReq,
    input  logic [ADDR_W-1:0]             dispAddr,
    output logic                          dispValid,
    output logic [DATA_W-1:0]             dispData,
    input  logic                          hostWr,
    input  logic [ADDR_W-1:0]             hostAddr,
    input  logic [DATA_W-1:0]             hostData,
    output logic                          hostFull,
    output logic [$clog2(FIFO_DEPTH):0]   hostCount,
    output logic                          hostOverflow,
    output logic [ADDR_W-1:0]             ramAddr,
    output logic [DATA_W-1:0]             ramWrData,
    output logic                          ramWe,
    output logic                          ramRe,
    input  logic [DATA_W-1:0]             ramRdData
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DepthCnt = CNT_W'(FIFO_DEPTH);

    // FIFO storage (no reset needed: only entries below the count are ever read)
    logic [ADDR_W-1:0] fifoAddr [FIFO_DEPTH];
    logic [DATA_W-1:0] fifoData [FIFO_DEPTH];

    logic [PTR_W-1:0]  wrPtrQ, wrPtrD;
    logic [PTR_W-1:0]  rdPtrQ, rdPtrD;
    logic [CNT_W-1:0]  countQ, countD;
    logic              overflowQ, overflowD;

    logic [ADDR_W-1:0] ramAddrQ, ramAddrD;
    logic [DATA_W-1:0] ramWrDataQ, ramWrDataD;
    logic              ramWeQ, ramWeD;
    logic              ramReQ, ramReD;

    // rdPendQ marks the cycle in which ramRdData carries a display read result
    logic              rdPendQ;
    logic              dispValidQ;
    logic [DATA_W-1:0] dispDataQ, dispDataD;

    logic fifoFull, fifoEmpty, push, pop;

    // Full is judged on the pre-pop count, so a write on a full FIFO is dropped
    // even when the same edge also pops an entry.
    always_comb begin
        fifoFull  = (countQ == DepthCnt);
        fifoEmpty = (countQ == '0);
        push      = hostWr && !fifoFull;
        pop       = !dispReq && !fifoEmpty;

        wrPtrD    = push ? wrPtrQ + 1'b1 : wrPtrQ;
        rdPtrD    = pop  ? rdPtrQ + 1'b1 : rdPtrQ;

        countD = countQ;
        if (push && !pop) begin
            countD = countQ + 1'b1;
        end else if (pop && !push) begin
            countD = countQ - 1'b1;
        end

        overflowD = overflowQ || (hostWr && fifoFull);
    end

    // Slot decision: display read, else FIFO drain, else idle (address/data hold).
    always_comb begin
        ramAddrD   = ramAddrQ;
        ramWrDataD = ramWrDataQ;
        ramReD     = 1'b0;
        ramWeD     = 1'b0;
        if (dispReq) begin
            ramReD   = 1'b1;
            ramAddrD = dispAddr;
        end else if (pop) begin
            ramWeD     = 1'b1;
            ramAddrD   = fifoAddr[rdPtrQ];
            ramWrDataD = fifoData[rdPtrQ];
        end
    end

    always_comb begin
        dispDataD = rdPendQ ? ramRdData : dispDataQ;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifoAddr[wrPtrQ] <= hostAddr;
            fifoData[wrPtrQ] <= hostData;
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            wrPtrQ     <= '0;
            rdPtrQ     <= '0;
            countQ     <= '0;
            overflowQ  <= 1'b0;
            ramAddrQ   <= '0;
            ramWrDataQ <= '0;
            ramWeQ     <= 1'b0;
            ramReQ     <= 1'b0;
            rdPendQ    <= 1'b0;
            dispValidQ <= 1'b0;
            dispDataQ  <= '0;
        end else begin
            wrPtrQ     <= wrPtrD;
            rdPtrQ     <= rdPtrD;
            countQ     <= countD;
            overflowQ  <= overflowD;
            ramAddrQ   <= ramAddrD;
            ramWrDataQ <= ramWrDataD;
            ramWeQ     <= ramWeD;
            ramReQ     <= ramReD;
            rdPendQ    <= ramReQ;
            dispValidQ <= rdPendQ;
            dispDataQ  <= dispDataD;
        end
    end

    assign hostFull     = (countQ == DepthCnt);
    assign hostCount    = countQ;
    assign hostOverflow = overflowQ;
    assign ramAddr      = ramAddrQ;
    assign ramWrData    = ramWrDataQ;
    assign ramWe        = ramWeQ;
    assign ramRe        = ramReQ;
    assign dispValid    = dispValidQ;
    assign dispData     = dispDataQ;

endmodule
